// File: rtl/nn_mem_pkg.sv
// Shared constants and FSM encoding for the NN memory port arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package nn_mem_pkg;

   localparam int WORDSIZE_DEF = 8;
   localparam int ADDRSIZE_DEF = 4;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set bit of req_i, searching upward from start_i with wraparound.
// Latency: combinational.
// Backpressure: none. Bits set in excl_i are never picked.
module rr_priority_picker #(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0]         req_i,
   input  logic [$clog2(NREQ)-1:0] start_i,
   input  logic [NREQ-1:0]         excl_i,
   output logic [NREQ-1:0]         win_onehot_o,
   output logic [$clog2(NREQ)-1:0] win_idx_o,
   output logic                    win_vld_o
);

   localparam int IW = $clog2(NREQ);

   // Walk the requesters from the start pointer and take the first eligible one.
   always_comb begin
      int idx;
      idx          = 0;
      win_onehot_o = '0;
      win_idx_o    = '0;
      win_vld_o    = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(start_i) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!win_vld_o && req_i[idx] && !excl_i[idx]) begin
            win_vld_o         = 1'b1;
            win_onehot_o[idx] = 1'b1;
            win_idx_o         = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares one single-port memory among NREQ requesters: round-robin with bounded locked bursts.
// Latency: grant and memory drive are combinational; read data and rvalid follow one cycle later.
// Backpressure: a requester without gnt must hold its request; a locked owner yields after MAX_BURST if others wait.
module memory_port_arbiter
   import nn_mem_pkg::*;
#(
   parameter int WORDSIZE  = WORDSIZE_DEF,
   parameter int ADDRSIZE  = ADDRSIZE_DEF,
   parameter int NREQ      = 2,
   parameter int MAX_BURST = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0]          lock,
   input  logic [NREQ-1:0]          we,
   input  logic [NREQ*ADDRSIZE-1:0] addr,
   input  logic [NREQ*WORDSIZE-1:0] wdata,
   output logic [NREQ-1:0]          gnt,
   output logic [NREQ-1:0]          rvalid,
   output logic [WORDSIZE-1:0]      rdata,
   output logic                     busy,
   output logic                     mem_we,
   output logic [ADDRSIZE-1:0]      mem_addr,
   output logic [WORDSIZE-1:0]      mem_wdata,
   input  logic [WORDSIZE-1:0]      mem_rdata
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(MAX_BURST + 1);

   arb_state_e          state_q, state_d;
   logic [IW-1:0]       owner_q, owner_d;
   logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [NREQ-1:0]     rvalid_q, rvalid_d;
   logic [WORDSIZE-1:0] rdata_q, rdata_d;
   logic [ADDRSIZE-1:0] last_addr_q, last_addr_d;
   logic [WORDSIZE-1:0] last_wdata_q, last_wdata_d;

   logic [NREQ-1:0]     owner_oh, excl, pick_oh;
   logic [IW-1:0]       pick_idx, win;
   logic                pick_vld, locked, cnt_full, other_req, keep, gnt_vld;

   // Decide whether the current burst owner keeps the port or must yield to a waiting requester.
   always_comb begin
      owner_oh           = '0;
      owner_oh[owner_q]  = 1'b1;
      locked             = (state_q == ST_LOCKED);
      cnt_full           = (cnt_q == CW'(MAX_BURST));
      other_req          = |(req & ~owner_oh);
      keep               = locked && req[owner_q] && (!cnt_full || !other_req);
      excl               = (locked && req[owner_q] && cnt_full && other_req) ? owner_oh : '0;
   end

   rr_priority_picker #(.NREQ(NREQ)) u_picker (
      .req_i        (req),
      .start_i      (rr_ptr_q),
      .excl_i       (excl),
      .win_onehot_o (pick_oh),
      .win_idx_o    (pick_idx),
      .win_vld_o    (pick_vld)
   );

   // Grant, memory drive and next-state; nothing is granted or written while reset is asserted.
   always_comb begin
      gnt_vld      = rst_n && (keep || pick_vld);
      win          = keep ? owner_q : pick_idx;
      gnt          = '0;
      mem_we       = 1'b0;
      mem_addr     = last_addr_q;
      mem_wdata    = last_wdata_q;
      state_d      = state_q;
      owner_d      = owner_q;
      rr_ptr_d     = rr_ptr_q;
      cnt_d        = cnt_q;
      rvalid_d     = '0;
      rdata_d      = rdata_q;
      last_addr_d  = last_addr_q;
      last_wdata_d = last_wdata_q;
      if (gnt_vld) begin
         gnt          = keep ? owner_oh : pick_oh;
         mem_we       = we[win];
         mem_addr     = addr[int'(win)*ADDRSIZE +: ADDRSIZE];
         mem_wdata    = wdata[int'(win)*WORDSIZE +: WORDSIZE];
         last_addr_d  = mem_addr;
         last_wdata_d = mem_wdata;
         rr_ptr_d     = (win == IW'(NREQ-1)) ? '0 : win + IW'(1);
         if (!we[win]) begin
            rvalid_d = gnt;
            rdata_d  = mem_rdata;
         end
         if (lock[win]) begin
            state_d = ST_LOCKED;
            owner_d = win;
            cnt_d   = (locked && owner_q == win && !cnt_full) ? cnt_q + CW'(1) : CW'(1);
         end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      end else begin
         // No grant means the owner (if any) has dropped its request.
         state_d = ST_IDLE;
         cnt_d   = '0;
      end
   end

   // State register with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         owner_q      <= '0;
         rr_ptr_q     <= '0;
         cnt_q        <= '0;
         rvalid_q     <= '0;
         rdata_q      <= '0;
         last_addr_q  <= '0;
         last_wdata_q <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         rr_ptr_q     <= rr_ptr_d;
         cnt_q        <= cnt_d;
         rvalid_q     <= rvalid_d;
         rdata_q      <= rdata_d;
         last_addr_q  <= last_addr_d;
         last_wdata_q <= last_wdata_d;
      end
   end

   assign rvalid = rvalid_q;
   assign rdata  = rdata_q;
   assign busy   = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter with a behavioural single-port memory attached.
// Latency: checks grant in-cycle and read data one cycle after the grant.
// Backpressure: n/a.
module tb_memory_port_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] req = '0, lock = '0, we = '0;
   logic [7:0] addr = '0;
   logic [15:0] wdata = '0;
   logic [1:0] gnt, rvalid;
   logic [7:0] rdata, mem_wdata, mem_rdata;
   logic       busy, mem_we;
   logic [3:0] mem_addr;

   memory_port_arbiter #(.WORDSIZE(8), .ADDRSIZE(4), .NREQ(2), .MAX_BURST(4)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .we(we), .addr(addr), .wdata(wdata),
      .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Behavioural memory: preloaded on the first edge, then written by the arbiter.
   logic [7:0] mem [16];
   logic       preload = 1'b1;
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 16; i++) mem[i] <= 8'h10 + 8'(i);
      end else if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end
   assign mem_rdata = mem[mem_addr];

   typedef struct {
      logic [1:0] rv;
      logic [7:0] dat;
   } sb_t;

   typedef struct {
      logic [1:0] r, l, w;
      logic [3:0] a0, a1;
      logic [7:0] d0, d1;
      logic [1:0] eg;
      logic       eb;
   } vec_t;

   logic [7:0] shadow [16];
   logic [3:0] exp_addr = '0;
   sb_t        sb [$];
   int         checks = 0;
   int         errors = 0;

   task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string nm);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One clock cycle: drive, check grant/memory drive, commit, then check read return.
   task automatic cycle(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w,
                        input logic [3:0] a0, input logic [3:0] a1,
                        input logic [7:0] d0, input logic [7:0] d1,
                        input logic [1:0] eg, input logic eb, input string nm);
      int  wi;
      sb_t e;
      req = r; lock = l; we = w; addr = {a1, a0}; wdata = {d1, d0};
      #2;
      chk(32'(gnt), 32'(eg), {nm, ".gnt"});
      if (eg != 2'b00) begin
         wi = eg[1] ? 1 : 0;
         exp_addr = (wi == 1) ? a1 : a0;
         chk(32'(mem_we), 32'(w[wi]), {nm, ".mem_we"});
         e.rv  = w[wi] ? 2'b00 : eg;
         e.dat = shadow[exp_addr];
         if (w[wi]) shadow[exp_addr] = (wi == 1) ? d1 : d0;
      end else begin
         chk(32'(mem_we), 32'd0, {nm, ".mem_we"});
         e.rv  = 2'b00;
         e.dat = 8'h00;
      end
      chk(32'(mem_addr), 32'(exp_addr), {nm, ".mem_addr"});
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      chk(32'(rvalid), 32'(e.rv), {nm, ".rvalid"});
      if (e.rv != 2'b00) chk(32'(rdata), 32'(e.dat), {nm, ".rdata"});
      chk(32'(busy), 32'(eb), {nm, ".busy"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   vec_t tbl [10];

   initial begin
      tbl[0] = '{2'b11, 2'b00, 2'b00, 4'd5, 4'd6, 8'h00, 8'h00, 2'b01, 1'b0};
      tbl[1] = '{2'b11, 2'b00, 2'b00, 4'd5, 4'd6, 8'h00, 8'h00, 2'b10, 1'b0};
      tbl[2] = '{2'b11, 2'b00, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00, 2'b01, 1'b0};
      tbl[3] = '{2'b11, 2'b00, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00, 2'b10, 1'b0};
      tbl[4] = '{2'b01, 2'b00, 2'b01, 4'd3, 4'd0, 8'hA5, 8'h00, 2'b01, 1'b0};
      tbl[5] = '{2'b10, 2'b00, 2'b00, 4'd0, 4'd3, 8'h00, 8'h00, 2'b10, 1'b0};
      tbl[6] = '{2'b00, 2'b00, 2'b00, 4'd7, 4'd8, 8'h00, 8'h00, 2'b00, 1'b0};
      tbl[7] = '{2'b10, 2'b00, 2'b10, 4'd0, 4'd9, 8'h00, 8'h3C, 2'b10, 1'b0};
      tbl[8] = '{2'b11, 2'b00, 2'b00, 4'd9, 4'd3, 8'h00, 8'h00, 2'b01, 1'b0};
      tbl[9] = '{2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0};
      for (int i = 0; i < 16; i++) shadow[i] = 8'h10 + 8'(i);

      // Reset with both requesters trying to write: nothing granted, nothing written.
      req = 2'b11; we = 2'b11; addr = {4'd6, 4'd5}; wdata = 16'hFFFF;
      @(posedge clk); #1 preload = 1'b0;
      repeat (3) begin
         @(posedge clk); #2;
         chk(32'(gnt), 32'd0, "rst.gnt");
         chk(32'(mem_we), 32'd0, "rst.mem_we");
         chk(32'(busy), 32'd0, "rst.busy");
         chk(32'(rvalid), 32'd0, "rst.rvalid");
         chk(32'(rdata), 32'd0, "rst.rdata");
      end
      req = 2'b00; we = 2'b00;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Round-robin alternation, write-then-read, idle hold, and reset-time contents.
      for (int i = 0; i < 10; i++)
         cycle(tbl[i].r, tbl[i].l, tbl[i].w, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1,
               tbl[i].eg, tbl[i].eb, $sformatf("vec%0d", i));

      // Burst bound: requester 0 locked, requester 1 waiting -> exactly four grants to 0.
      cycle(2'b01, 2'b01, 2'b00, 4'd3, 4'd9, 8'h00, 8'h00, 2'b01, 1'b1, "burst0");
      for (int i = 1; i < 4; i++)
         cycle(2'b11, 2'b01, 2'b00, 4'd3, 4'd9, 8'h00, 8'h00, 2'b01, 1'b1, $sformatf("burst%0d", i));
      cycle(2'b11, 2'b01, 2'b00, 4'd3, 4'd9, 8'h00, 8'h00, 2'b10, 1'b0, "burst_yield");

      // Lone locked requester keeps the port indefinitely.
      for (int i = 0; i < 8; i++)
         cycle(2'b01, 2'b01, 2'b00, 4'd4, 4'd0, 8'h00, 8'h00, 2'b01, 1'b1, $sformatf("solo%0d", i));
      cycle(2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0, "solo_drop");

      // Early release: owner drops req, the other requester wins in the same cycle.
      cycle(2'b01, 2'b01, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00, 2'b01, 1'b1, "early0");
      cycle(2'b01, 2'b01, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00, 2'b01, 1'b1, "early1");
      cycle(2'b10, 2'b00, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00, 2'b10, 1'b0, "early_rel");

      // Asynchronous reset in the middle of a locked read burst.
      cycle(2'b01, 2'b01, 2'b00, 4'd3, 4'd0, 8'h00, 8'h00, 2'b01, 1'b1, "mid0");
      req = 2'b01; lock = 2'b01; we = 2'b00; addr = {4'd0, 4'd9};
      #2;
      chk(32'(gnt), 32'b01, "mid1.gnt");
      #1 rst_n = 1'b0;
      #1;
      chk(32'(busy), 32'd0, "midrst.busy");
      chk(32'(rvalid), 32'd0, "midrst.rvalid");
      chk(32'(rdata), 32'd0, "midrst.rdata");
      chk(32'(gnt), 32'd0, "midrst.gnt");
      chk(32'(mem_we), 32'd0, "midrst.mem_we");
      @(posedge clk); #1;
      chk(32'(rvalid), 32'd0, "midrst.rvalid_edge");
      chk(32'(busy), 32'd0, "midrst.busy_edge");
      req = 2'b00; lock = 2'b00;
      rst_n = 1'b1;
      exp_addr = 4'd0;
      cycle(2'b11, 2'b00, 2'b00, 4'd5, 4'd6, 8'h00, 8'h00, 2'b01, 1'b0, "post_rst");
      cycle(2'b11, 2'b00, 2'b00, 4'd5, 4'd6, 8'h00, 8'h00, 2'b10, 1'b0, "post_rst2");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
